traffic_phase_ctrl: RTL and testbench

Parametrised multi-approach traffic-light controller: the next generation of the single-road car/pedestrian controller. It sequences NUM_PHASES approaches round-robin, with a vehicle head and a pedestrian head per approach. Debounced pedestrian requests can shorten the current green. It also exports a 0–9 countdown for the existing MAX7219 display path. It sits between the board inputs (switch, request buttons) and the light/display pins of the top-level wrapper, and generates its own 100 ms tick from the system clock.

---
 rtl/traffic_phase_ctrl.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin multi-approach traffic light sequencer with debounced pedestrian requests and countdown
module traffic_phase_ctrl #(
  parameter int NUM_PHASES    = 2,
  parameter int TICK_DIV      = 1_000_000,
  parameter int T_RED_YELLOW  = 10,
  parameter int T_GREEN       = 150,
  parameter int T_GREEN_MIN   = 50,
  parameter int T_GREEN_BLINK = 40,
  parameter int T_YELLOW      = 30,
  parameter int T_ALL_RED     = 20,
  parameter int BLINK_TICKS   = 5,
  parameter int DEBOUNCE      = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_PHASES-1:0]   ped_req,
  output logic [3*NUM_PHASES-1:0] car_lights,
  output logic [2*NUM_PHASES-1:0] ped_lights,
  output logic [1:0]              active_phase,
  output logic [NUM_PHASES-1:0]   ped_pending,
  output logic [3:0]              countdown,
  output logic                    countdown_valid
);
  localparam int TW = 16;
  localparam int CW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] L_AR = TW'(T_ALL_RED - 1);
  localparam logic [TW-1:0] L_RY = TW'(T_RED_YELLOW - 1);
  localparam logic [TW-1:0] L_G = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] L_GM = TW'(T_GREEN_MIN - 1);
  localparam logic [TW-1:0] L_GB = TW'(T_GREEN_BLINK - 1);
  localparam logic [TW-1:0] L_Y = TW'(T_YELLOW - 1);
  localparam logic [CW-1:0] L_TICK = CW'(TICK_DIV - 1);
  localparam logic [BW-1:0] L_BL = BW'(BLINK_TICKS - 1);
  localparam logic [DW-1:0] L_DB = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] L_DBF = DW'(DEBOUNCE);
  localparam logic [1:0] L_LAST = 2'(NUM_PHASES - 1);

  typedef enum logic [2:0] {IDLE, ALL_RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW} state_t;

  state_t state, state_nx;
  logic [CW-1:0] tick_cnt;
  logic tick, blink, early, in_green;
  logic [TW-1:0] timer;
  logic [BW-1:0] blink_cnt;
  logic [NUM_PHASES-1:0] req_s1, req_s2, act_oh, accept, clr;
  logic [DW-1:0] deb_cnt [NUM_PHASES];
  int glen, rem;

  assign tick = tick_cnt == L_TICK;
  assign act_oh = {{(NUM_PHASES-1){1'b0}}, 1'b1} << active_phase;
  assign in_green = state == GREEN || state == GREEN_BLINK;
  assign early = |(ped_pending & ~act_oh);
  assign clr = (state == RED_YELLOW && state_nx == GREEN) ? act_oh : '0;

  // debounced request acceptance; the served approach cannot request during its own green
  always_comb
    for (int j = 0; j < NUM_PHASES; j++)
      accept[j] = req_s2[j] && deb_cnt[j] == L_DB && !(act_oh[j] && in_green);

  // next state, light decode and countdown
  always_comb begin
    state_nx = state;
    car_lights = '0;
    ped_lights = '0;
    glen = early ? T_GREEN_MIN : T_GREEN;
    if (!enable) state_nx = IDLE;
    else if (state == IDLE) state_nx = ALL_RED;
    else if (tick)
      case (state)
        ALL_RED:     if (timer == L_AR) state_nx = RED_YELLOW;
        RED_YELLOW:  if (timer == L_RY) state_nx = GREEN;
        GREEN:       if (timer == L_G || (early && timer >= L_GM)) state_nx = GREEN_BLINK;
        GREEN_BLINK: if (timer == L_GB) state_nx = YELLOW;
        YELLOW:      if (timer == L_Y) state_nx = ALL_RED;
        default:     state_nx = IDLE;
      endcase
    for (int k = 0; k < NUM_PHASES; k++) begin
      car_lights[3*k +: 3] = state == IDLE ? {1'b0, blink, 1'b0} :
                             !act_oh[k] ? 3'b001 :
                             state == ALL_RED ? 3'b001 :
                             state == RED_YELLOW ? 3'b011 :
                             state == GREEN ? 3'b100 :
                             state == GREEN_BLINK ? {blink, 2'b00} : 3'b010;
      ped_lights[2*k +: 2] = state == IDLE ? 2'b00 :
                             !act_oh[k] ? 2'b01 :
                             state == GREEN ? 2'b10 :
                             state == GREEN_BLINK ? {blink, 1'b0} : 2'b01;
    end
    rem = state == GREEN ? (glen - int'(timer) - 1 > 0 ? glen - int'(timer) - 1 : 0) + T_GREEN_BLINK
                         : T_GREEN_BLINK - int'(timer) - 1;
    countdown = !in_green ? 4'd0 : rem / 10 > 9 ? 4'd9 : 4'(rem / 10);
    countdown_valid = in_green;
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // 100 ms tick divider, restarted whenever IDLE is entered
  always_ff @(posedge clk or posedge rst)
    if (rst) tick_cnt <= '0;
    else if (!enable && state != IDLE) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

  // per-state tick timer and blink generator; both restart off on every state change
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      timer <= '0;
      blink_cnt <= '0;
      blink <= 1'b0;
    end else if (state_nx != state) begin
      timer <= '0;
      blink_cnt <= '0;
      blink <= 1'b0;
    end else if (tick) begin
      timer <= state == IDLE ? '0 : timer + TW'(1);
      if (state == IDLE || state == GREEN_BLINK) begin
        blink_cnt <= blink_cnt == L_BL ? '0 : blink_cnt + BW'(1);
        blink <= blink ^ (blink_cnt == L_BL);
      end
    end

  // served approach advances when yellow ends
  always_ff @(posedge clk or posedge rst)
    if (rst) active_phase <= 2'd0;
    else if (state_nx == IDLE) active_phase <= 2'd0;
    else if (state == YELLOW && state_nx == ALL_RED) active_phase <= active_phase == L_LAST ? 2'd0 : active_phase + 2'd1;

  // request synchroniser, debounce counters and pending latches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_s1 <= '0;
      req_s2 <= '0;
      ped_pending <= '0;
      for (int j = 0; j < NUM_PHASES; j++) deb_cnt[j] <= '0;
    end else begin
      req_s1 <= ped_req;
      req_s2 <= req_s1;
      ped_pending <= enable ? (ped_pending | accept) & ~clr : '0;
      for (int j = 0; j < NUM_PHASES; j++)
        deb_cnt[j] <= !req_s2[j] ? '0 : deb_cnt[j] == L_DBF ? deb_cnt[j] : deb_cnt[j] + DW'(1);
    end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed checks of sequencing, requests, countdown, idle and reset behaviour
module tb_traffic_phase_ctrl;
  logic clk = 1'b0;
  logic rst, enable;
  logic [1:0] ped_req, ped_req_b;
  logic [5:0] car_lights, car_b;
  logic [3:0] ped_lights, ped_b;
  logic [1:0] active_phase, act_b, ped_pending, pend_b;
  logic [3:0] countdown, countdown_b;
  logic countdown_valid, countdown_valid_b;
  int n_chk = 0;
  int n_fail = 0;
  int now_e = 0;

  typedef struct packed {
    logic [9:0] e;
    logic [5:0] car;
    logic [3:0] ped;
    logic [1:0] act;
    logic cv;
  } row_t;

  traffic_phase_ctrl #(
    .NUM_PHASES(2), .TICK_DIV(4), .T_RED_YELLOW(3), .T_GREEN(8), .T_GREEN_MIN(3),
    .T_GREEN_BLINK(2), .T_YELLOW(2), .T_ALL_RED(2), .BLINK_TICKS(2), .DEBOUNCE(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ped_req(ped_req),
    .car_lights(car_lights), .ped_lights(ped_lights), .active_phase(active_phase),
    .ped_pending(ped_pending), .countdown(countdown), .countdown_valid(countdown_valid)
  );

  traffic_phase_ctrl #(
    .NUM_PHASES(2), .TICK_DIV(2), .T_RED_YELLOW(2), .T_GREEN(150), .T_GREEN_MIN(50),
    .T_GREEN_BLINK(40), .T_YELLOW(2), .T_ALL_RED(2), .BLINK_TICKS(5), .DEBOUNCE(4)
  ) dut_cd (
    .clk(clk), .rst(rst), .enable(enable), .ped_req(ped_req_b),
    .car_lights(car_b), .ped_lights(ped_b), .active_phase(act_b),
    .ped_pending(pend_b), .countdown(countdown_b), .countdown_valid(countdown_valid_b)
  );

  always #5 clk = ~clk;

  task automatic upto(int e);
    repeat (e - now_e) @(posedge clk);
    #1;
    now_e = e;
  endtask

  task automatic restart(logic en);
    @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b0;
    ped_req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    enable = en;
    now_e = 0;
  endtask

  task automatic test_reset();
    #12;
    if ({car_lights, ped_lights, active_phase, ped_pending} !== 14'd0) begin
      $display("FAIL reset_lights: got car=%b ped=%b act=%0d pend=%b, want all 0", car_lights, ped_lights, active_phase, ped_pending);
      n_fail++;
    end
    n_chk++;
    if ({countdown, countdown_valid} !== 5'd0) begin
      $display("FAIL reset_countdown: got cd=%0d cv=%b, want 0 0", countdown, countdown_valid);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_idle_blink();
    int ev [4] = '{7, 8, 15, 16};
    logic [5:0] ec [4] = '{6'b000000, 6'b010010, 6'b010010, 6'b000000};
    restart(1'b0);
    for (int i = 0; i < 4; i++) begin
      upto(ev[i]);
      if ({car_lights, ped_lights, countdown_valid} !== {ec[i], 4'b0000, 1'b0}) begin
        $display("FAIL idle_blink @%0d: got car=%b ped=%b cv=%b, want car=%b ped=0000 cv=0", ev[i], car_lights, ped_lights, countdown_valid, ec[i]);
        n_fail++;
      end
      n_chk++;
    end
  endtask

  task automatic test_cycle();
    row_t tbl [11];
    tbl = '{
      '{10'd1,  6'b001001, 4'b0101, 2'd0, 1'b0},
      '{10'd7,  6'b001001, 4'b0101, 2'd0, 1'b0},
      '{10'd8,  6'b001011, 4'b0101, 2'd0, 1'b0},
      '{10'd19, 6'b001011, 4'b0101, 2'd0, 1'b0},
      '{10'd20, 6'b001100, 4'b0110, 2'd0, 1'b1},
      '{10'd51, 6'b001100, 4'b0110, 2'd0, 1'b1},
      '{10'd52, 6'b001000, 4'b0100, 2'd0, 1'b1},
      '{10'd59, 6'b001000, 4'b0100, 2'd0, 1'b1},
      '{10'd60, 6'b001010, 4'b0101, 2'd0, 1'b0},
      '{10'd67, 6'b001010, 4'b0101, 2'd0, 1'b0},
      '{10'd68, 6'b001001, 4'b0101, 2'd1, 1'b0}
    };
    restart(1'b1);
    foreach (tbl[i]) begin
      upto(int'(tbl[i].e));
      if ({car_lights, ped_lights, active_phase, countdown_valid, countdown} !== {tbl[i].car, tbl[i].ped, tbl[i].act, tbl[i].cv, 4'd0}) begin
        $display("FAIL cycle @%0d: got car=%b ped=%b act=%0d cv=%b cd=%0d, want car=%b ped=%b act=%0d cv=%b cd=0",
                 tbl[i].e, car_lights, ped_lights, active_phase, countdown_valid, countdown, tbl[i].car, tbl[i].ped, tbl[i].act, tbl[i].cv);
        n_fail++;
      end
      n_chk++;
    end
  endtask

  task automatic test_early_exit();
    restart(1'b1);
    upto(24);
    ped_req = 2'b10;
    upto(29);
    if (ped_pending !== 2'b00) begin
      $display("FAIL early_pre_accept: got pend=%b, want 00", ped_pending);
      n_fail++;
    end
    n_chk++;
    upto(30);
    if (ped_pending !== 2'b10) begin
      $display("FAIL early_accept: got pend=%b, want 10", ped_pending);
      n_fail++;
    end
    n_chk++;
    ped_req = 2'b00;
    upto(31);
    if (car_lights !== 6'b001100) begin
      $display("FAIL early_still_green: got car=%b, want 001100", car_lights);
      n_fail++;
    end
    n_chk++;
    upto(32);
    if (car_lights !== 6'b001000) begin
      $display("FAIL early_blink_entry: got car=%b, want 001000", car_lights);
      n_fail++;
    end
    n_chk++;
    upto(48);
    if ({car_lights, active_phase} !== {6'b001001, 2'd1}) begin
      $display("FAIL early_advance: got car=%b act=%0d, want 001001 1", car_lights, active_phase);
      n_fail++;
    end
    n_chk++;
    upto(67);
    if ({car_lights, ped_pending} !== {6'b011001, 2'b10}) begin
      $display("FAIL early_ry1: got car=%b pend=%b, want 011001 10", car_lights, ped_pending);
      n_fail++;
    end
    n_chk++;
    upto(68);
    if ({car_lights, ped_lights, ped_pending} !== {6'b100001, 4'b1001, 2'b00}) begin
      $display("FAIL early_green1_clear: got car=%b ped=%b pend=%b, want 100001 1001 00", car_lights, ped_lights, ped_pending);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_reject();
    restart(1'b1);
    upto(1);
    ped_req = 2'b01;
    upto(4);
    ped_req = 2'b00;
    upto(10);
    if (ped_pending !== 2'b00) begin
      $display("FAIL reject_short_pulse: got pend=%b, want 00", ped_pending);
      n_fail++;
    end
    n_chk++;
    upto(20);
    ped_req = 2'b01;
    upto(30);
    if (ped_pending !== 2'b00) begin
      $display("FAIL reject_own_green: got pend=%b, want 00", ped_pending);
      n_fail++;
    end
    n_chk++;
    upto(40);
    ped_req = 2'b00;
    upto(51);
    if ({car_lights, ped_pending} !== {6'b001100, 2'b00}) begin
      $display("FAIL reject_full_green: got car=%b pend=%b, want 001100 00", car_lights, ped_pending);
      n_fail++;
    end
    n_chk++;
    upto(60);
    ped_req = 2'b01;
    upto(64);
    ped_req = 2'b00;
    upto(65);
    if (ped_pending !== 2'b00) begin
      $display("FAIL accept_too_early: got pend=%b, want 00", ped_pending);
      n_fail++;
    end
    n_chk++;
    upto(66);
    if (ped_pending !== 2'b01) begin
      $display("FAIL accept_full_debounce: got pend=%b, want 01", ped_pending);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_enable_drop();
    restart(1'b1);
    upto(1);
    ped_req = 2'b10;
    upto(7);
    ped_req = 2'b00;
    if (ped_pending !== 2'b10) begin
      $display("FAIL drop_pending_set: got pend=%b, want 10", ped_pending);
      n_fail++;
    end
    n_chk++;
    upto(22);
    if (car_lights !== 6'b001100) begin
      $display("FAIL drop_in_green: got car=%b, want 001100", car_lights);
      n_fail++;
    end
    n_chk++;
    enable = 1'b0;
    upto(23);
    if ({car_lights, ped_lights, active_phase, ped_pending, countdown_valid} !== 15'd0) begin
      $display("FAIL drop_idle: got car=%b ped=%b act=%0d pend=%b cv=%b, want all 0", car_lights, ped_lights, active_phase, ped_pending, countdown_valid);
      n_fail++;
    end
    n_chk++;
    enable = 1'b1;
    upto(24);
    if ({car_lights, ped_lights, active_phase} !== {6'b001001, 4'b0101, 2'd0}) begin
      $display("FAIL drop_restart: got car=%b ped=%b act=%0d, want 001001 0101 0", car_lights, ped_lights, active_phase);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_reset_mid();
    restart(1'b1);
    upto(120);
    ped_req = 2'b01;
    upto(126);
    ped_req = 2'b00;
    if (ped_pending !== 2'b01) begin
      $display("FAIL rstmid_pending: got pend=%b, want 01", ped_pending);
      n_fail++;
    end
    n_chk++;
    upto(130);
    if ({car_lights, active_phase} !== {6'b010001, 2'd1}) begin
      $display("FAIL rstmid_yellow1: got car=%b act=%0d, want 010001 1", car_lights, active_phase);
      n_fail++;
    end
    n_chk++;
    #3;
    rst = 1'b1;
    #1;
    if ({car_lights, ped_lights, active_phase, ped_pending, countdown_valid} !== 15'd0) begin
      $display("FAIL rstmid_async: got car=%b ped=%b act=%0d pend=%b cv=%b, want all 0", car_lights, ped_lights, active_phase, ped_pending, countdown_valid);
      n_fail++;
    end
    n_chk++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    now_e = 0;
    upto(1);
    if ({car_lights, ped_lights, active_phase, ped_pending} !== {6'b001001, 4'b0101, 2'd0, 2'b00}) begin
      $display("FAIL rstmid_restart: got car=%b ped=%b act=%0d pend=%b, want 001001 0101 0 00", car_lights, ped_lights, active_phase, ped_pending);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_countdown();
    int ev [10] = '{7, 8, 207, 208, 307, 308, 367, 368, 387, 388};
    int ecd [10] = '{0, 9, 9, 8, 4, 3, 1, 0, 0, 0};
    logic ecv [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    restart(1'b1);
    for (int i = 0; i < 10; i++) begin
      upto(ev[i]);
      if ({countdown_b, countdown_valid_b} !== {4'(ecd[i]), ecv[i]}) begin
        $display("FAIL countdown @%0d: got cd=%0d cv=%b, want cd=%0d cv=%b", ev[i], countdown_b, countdown_valid_b, ecd[i], ecv[i]);
        n_fail++;
      end
      n_chk++;
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    ped_req = 2'b00;
    ped_req_b = 2'b00;
    test_reset();
    test_idle_blink();
    test_cycle();
    test_early_exit();
    test_reject();
    test_enable_drop();
    test_reset_mid();
    test_countdown();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
